regfile_scb: RTL and testbench



---
 rtl/regfile_scb.sv | 114 +++++++++++
 tb/tb_regfile_scb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scb
//  Description : Parametrised multi-port register file with a per-register
//                load-use scoreboard (pending bits). Combinational read
//                ports, one synchronous write port, synchronous clear.
//                Optional feature macro: REGFILE_BYPASS_EN
//                  defined   -> same-cycle write-through on read ports
//                  undefined -> new write data visible from the next cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]        wd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    input  logic [NUM_RD-1:0]            rd_en,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    input  logic                         busy_set,
    input  logic [ADDR_WIDTH-1:0]        busy_addr,
    input  logic                         flush,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic                         stall,
    output logic [(2**ADDR_WIDTH)-1:0]   busy_vec
);

    localparam int c_NREGS   = 2**ADDR_WIDTH;
    localparam bit c_ZERO_HW = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] r_regs [c_NREGS];
    logic [c_NREGS-1:0]    r_busy;
    logic [c_NREGS-1:0]    w_busy_next;
    logic                  w_wr_en;
    logic                  w_set_en;

    // Writes and load marks aimed at a hardwired zero register are dropped
    assign w_wr_en  = we       & ~(c_ZERO_HW & (wa == '0));
    assign w_set_en = busy_set & ~(c_ZERO_HW & (busy_addr == '0));

    // Register array: synchronous clear, then single write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wa] <= wd;
        end
    end

    // Pending-bit next state: flush beats everything, a new load beats a retiring one
    always_comb begin
        w_busy_next = r_busy;
        if (flush) begin
            w_busy_next = '0;
        end else begin
            if (we) begin
                w_busy_next[wa] = 1'b0;
            end
            if (w_set_en) begin
                w_busy_next[busy_addr] = 1'b1;
            end
        end
    end

    // Pending-bit register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Per-port combinational read data and busy lookup
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_is_zero;
        logic                  w_hit;
        logic                  w_keep_busy;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_busy;

        assign w_ra      = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_is_zero = c_ZERO_HW && (w_ra == '0);
`ifdef REGFILE_BYPASS_EN
        // A write landing this cycle is forwarded; its retiring load no longer
        // blocks unless a new load to the same register is issuing right now
        assign w_hit       = w_wr_en && (wa == w_ra);
        assign w_keep_busy = w_set_en && (busy_addr == w_ra);
`else
        assign w_hit       = 1'b0;
        assign w_keep_busy = 1'b0;
`endif
        assign w_data = w_is_zero ? '0 : (w_hit ? wd : r_regs[w_ra]);
        assign w_busy = w_is_zero ? 1'b0
                      : ((w_hit && !w_keep_busy) ? 1'b0 : r_busy[w_ra]);

        assign rd[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rd_busy[i]                     = w_busy;
    end

    assign stall    = |(rd_busy & rd_en);
    assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scb
//  Description : Self-checking bench for regfile_scb. Directed scenarios plus
//                randomized traffic compared against an array-based model;
//                a second instance covers a narrow 3-port, no-zero-reg build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic             reset, we, busy_set, flush, stall;
    logic [AW-1:0]    wa, busy_addr;
    logic [DW-1:0]    wd;
    logic [NR*AW-1:0] ra;
    logic [NR-1:0]    rd_en, rd_busy;
    logic [NR*DW-1:0] rd;
    logic [NREGS-1:0] busy_vec;

    regfile_scb dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd_en(rd_en), .rd(rd), .busy_set(busy_set), .busy_addr(busy_addr),
        .flush(flush), .rd_busy(rd_busy), .stall(stall), .busy_vec(busy_vec)
    );

    // Narrow instance: 16-bit, 8 registers, 3 read ports, register 0 ordinary
    logic        p_reset, p_we, p_busy_set, p_flush, p_stall;
    logic [2:0]  p_wa, p_busy_addr, p_rd_en, p_rd_busy;
    logic [15:0] p_wd;
    logic [8:0]  p_ra;
    logic [47:0] p_rd;
    logic [7:0]  p_busy_vec;

    regfile_scb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(3), .ZERO_REG(0)) dut_p (
        .clk(clk), .reset(p_reset), .we(p_we), .wa(p_wa), .wd(p_wd), .ra(p_ra),
        .rd_en(p_rd_en), .rd(p_rd), .busy_set(p_busy_set), .busy_addr(p_busy_addr),
        .flush(p_flush), .rd_busy(p_rd_busy), .stall(p_stall), .busy_vec(p_busy_vec)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural register contents and outstanding loads
    logic [DW-1:0]    m_regs [NREGS];
    logic [NREGS-1:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && we && (wa == a) && !(busy_set && (busy_addr == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic compare_all();
        logic         exp_stall;
        logic [AW-1:0] a;
        exp_stall = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a = ra[i*AW +: AW];
            check($sformatf("rd%0d", i), 64'(rd[i*DW +: DW]), 64'(exp_rd(a)));
            check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(a)));
            if (exp_busy(a) && rd_en[i]) exp_stall = 1'b1;
        end
        check("stall", 64'(stall), 64'(exp_stall));
        check("busy_vec", 64'(busy_vec), 64'(m_busy));
    endtask

    task automatic model_update();
        if (reset) begin
            foreach (m_regs[k]) m_regs[k] = '0;
            m_busy = '0;
        end else begin
            if (flush) begin
                m_busy = '0;
            end else begin
                if (we) m_busy[wa] = 1'b0;
                if (busy_set && (busy_addr != 0)) m_busy[busy_addr] = 1'b1;
            end
            if (we && (wa != 0)) m_regs[wa] = wd;
        end
    endtask

    // Check settled outputs, clock once, advance the model with the same inputs
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b0; we = 1'b0; busy_set = 1'b0; flush = 1'b0;
        wa = '0; busy_addr = '0; wd = '0; ra = '0; rd_en = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
        return AW'($urandom_range(0, 3));
    endfunction

    initial begin
        set_idle();
        p_reset = 1'b1; p_we = 1'b0; p_busy_set = 1'b0; p_flush = 1'b0;
        p_wa = '0; p_busy_addr = '0; p_wd = '0; p_ra = '0; p_rd_en = '0;

        // Reset state
        reset = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        tick();
        reset = 1'b0;
        #1;
        check("reset_rd0", 64'(rd[DW-1:0]), 64'(0));
        check("reset_stall", 64'(stall), 64'(0));

        // Reset discards written data
        we = 1'b1; wa = 5; wd = 32'h12345678;
        tick();
        we = 1'b0; ra[0 +: AW] = 5;
        #1;
        check("pre_reset_rd0", 64'(rd[DW-1:0]), 64'(32'h12345678));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_rd0", 64'(rd[DW-1:0]), 64'(0));
        check("post_reset_busy_vec", 64'(busy_vec), 64'(0));

        // Hardwired zero register ignores writes and load marks
        we = 1'b1; wa = 0; wd = '1; busy_set = 1'b1; busy_addr = 0;
        tick();
        set_idle(); ra[0 +: AW] = 0; rd_en = 2'b01;
        #1;
        check("zero_rd0", 64'(rd[DW-1:0]), 64'(0));
        check("zero_busy_bit0", 64'(busy_vec[0]), 64'(0));
        check("zero_stall", 64'(stall), 64'(0));

        // Write-through visibility
        set_idle(); we = 1'b1; wa = 7; wd = 32'h11111111;
        tick();
        wd = 32'hDEADBEEF; ra[AW +: AW] = 7;
        #1;
        check("byp_same_cycle_rd1", 64'(rd[DW +: DW]), 64'(BYP ? 32'hDEADBEEF : 32'h11111111));
        tick();
        we = 1'b0;
        #1;
        check("byp_next_cycle_rd1", 64'(rd[DW +: DW]), 64'(32'hDEADBEEF));

        // Load-use hazard
        set_idle(); busy_set = 1'b1; busy_addr = 9;
        tick();
        busy_set = 1'b0; ra[0 +: AW] = 9; rd_en = 2'b01;
        #1;
        check("lu_rd_busy0", 64'(rd_busy[0]), 64'(1));
        check("lu_stall", 64'(stall), 64'(1));
        rd_en = 2'b00;
        #1;
        check("lu_stall_unused", 64'(stall), 64'(0));
        rd_en = 2'b01; we = 1'b1; wa = 9; wd = 32'h99;
        #1;
        check("lu_wb_cycle_stall", 64'(stall), 64'(BYP ? 0 : 1));
        tick();
        we = 1'b0;
        #1;
        check("lu_after_wb_stall", 64'(stall), 64'(0));

        // New load beats retiring load; flush beats new load
        set_idle(); busy_set = 1'b1; busy_addr = 3;
        tick();
        we = 1'b1; wa = 3; wd = 32'h33;
        tick();
        set_idle();
        #1;
        check("set_beats_write", 64'(busy_vec[3]), 64'(1));
        flush = 1'b1; busy_set = 1'b1; busy_addr = 4;
        tick();
        set_idle();
        #1;
        check("flush_clears_all", 64'(busy_vec), 64'(0));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            we        = ($urandom_range(0, 1) == 1);
            busy_set  = ($urandom_range(0, 3) == 0);
            wa        = rnd_addr();
            busy_addr = rnd_addr();
            wd        = $urandom();
            for (int i = 0; i < NR; i++) ra[i*AW +: AW] = rnd_addr();
            rd_en     = NR'($urandom_range(0, 3));
            tick();
        end
        set_idle();

        // Narrow configuration: register 0 is ordinary, no aliasing with reg 7
        @(posedge clk);
        #1;
        p_reset = 1'b0;
        check("p_reset_busy_vec", 64'(p_busy_vec), 64'(0));
        p_we = 1'b1; p_wa = 3'd0; p_wd = 16'hA5A5;
        @(posedge clk);
        #1;
        p_wa = 3'd7; p_wd = 16'h5A5A;
        @(posedge clk);
        #1;
        p_we = 1'b0; p_ra = {3'd0, 3'd0, 3'd0};
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("p_rd%0d_reg0", i), 64'(p_rd[i*16 +: 16]), 64'(16'hA5A5));
        p_ra = {3'd7, 3'd0, 3'd7};
        #1;
        check("p_rd0_reg7", 64'(p_rd[15:0]), 64'(16'h5A5A));
        check("p_rd1_reg0", 64'(p_rd[31:16]), 64'(16'hA5A5));
        check("p_rd2_reg7", 64'(p_rd[47:32]), 64'(16'h5A5A));
        p_busy_set = 1'b1; p_busy_addr = 3'd0;
        @(posedge clk);
        #1;
        p_busy_set = 1'b0; p_ra = '0; p_rd_en = 3'b010;
        #1;
        check("p_busy_vec_reg0", 64'(p_busy_vec), 64'(8'h01));
        check("p_stall_reg0", 64'(p_stall), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
